jk_cmd_seq: RTL
===============

JK_CMD_SEQ -- requirements
Module: jk_cmd_seq

Interface
REQ-001 Parameter LEN_W, default 8: width of the command hold-length field.
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 cmd_valid  input  1  upstream command present.
REQ-005 cmd_ready  output  1  sequencer accepts the command this cycle.
REQ-006 cmd_code  input  2  requested JK code: 00 hold, 01 reset, 10 set, 11 toggle.
REQ-007 cmd_len  input  LEN_W  number of clk cycles to drive cmd_code.
REQ-008 jk  output  2  drive to the downstream JK flip-flop; jk[1]=J, jk[0]=K.
REQ-009 q_fb  input  1  q returned from the downstream JK flip-flop.
REQ-010 busy  output  1  a command is being driven.
REQ-011 done  output  1  one-cycle pulse on the final cycle of each command.
REQ-012 exp_q  output  1  modelled expected flip-flop state.
REQ-013 exp_vld  output  1  exp_q is known, because a set or reset has been applied.
REQ-014 err  output  1  sticky flag: q_fb disagreed with exp_q while checking.

Function
REQ-015 The FSM SHALL have exactly two states, IDLE and RUN.
REQ-016 A handshake SHALL occur when cmd_valid and cmd_ready are both high at a rising edge.
REQ-017 In IDLE: cmd_ready=1, jk=00, busy=0; a handshake moves to RUN and latches code and length.
REQ-018 In RUN: jk=latched code and busy=1; cnt loads the latched length and decrements each cycle.
REQ-019 cmd_len=0 SHALL be treated as 1.
REQ-020 The final RUN cycle is cnt==1: done=1 and cmd_ready=1.
REQ-021 A handshake in the final RUN cycle SHALL reload code and count and stay in RUN, with no idle bubble (back-to-back).
REQ-022 In RUN with cnt>1, cmd_ready=0; the cmd_* inputs are ignored.
REQ-023 If the final RUN cycle has no handshake, the next state is IDLE and jk returns to 00.
REQ-024 The jk output SHALL be registered: it changes only on clk edges or on reset.
REQ-025 exp_q SHALL update each edge from the jk value driven during that cycle: 00 hold, 01 to 0, 10 to 1, 11 invert.
REQ-026 exp_vld SHALL be set by the first edge with jk=01 or 10 and remain set until reset.
REQ-027 Each edge with exp_vld=1 SHALL compare q_fb against exp_q as registered one cycle earlier; a mismatch sets err.
REQ-028 The comparison SHALL align with a single-cycle-latency downstream flip-flop.
REQ-029 err SHALL stay set until rst; no other clear path exists.
REQ-030 The length counter SHALL NOT wrap: the maximum cmd_len of 2^LEN_W-1 drives exactly that many cycles.

Reset
REQ-031 While rst=1: state=IDLE, jk=00, cmd_ready=0, busy=0, done=0, cnt=0, exp_q=0, exp_vld=0, err=0.
REQ-032 rst asserted mid-command SHALL abort the command immediately, asynchronously, with jk forced to 00.
REQ-033 cmd_ready SHALL rise on the first clk edge after rst deasserts.

Structure
REQ-034 A shared package SHALL hold the JK code constants (HOLD=00, RST=01, SET=10, TGL=11) and the state encoding.
REQ-035 One sub-module, jk_model, SHALL implement the exp_q/exp_vld/err checker, reusable against any JK flip-flop.

Verification
REQ-036 Reset then cmd {10, len 3} -> jk=10 for exactly 3 cycles, done on the 3rd, then jk=00; exp_q=1, exp_vld=1.
REQ-037 Back-to-back {01,2},{11,4} with cmd_valid held -> jk 01,01,11,11,11,11 with no 00 gap; exp_q ends 0; done pulses twice.
REQ-038 cmd {00,0} -> one cycle of jk=00 with done=1; exp_vld stays 0 and err stays 0 for any q_fb.
REQ-039 Drive q_fb=0 during a {10,5} command after the first cycle -> err=1 and it remains 1 through later correct cycles.
REQ-040 Assert rst in the 2nd cycle of {11,10} -> jk=00, busy=0, exp_vld=0 immediately; the next command is accepted normally.
REQ-041 LEN_W=8, cmd {11,255} -> exactly 255 jk=11 cycles; exp_q returns the complement of its start value (odd count).

Source files
------------

// File: rtl/jk_cmd_seq_pkg.sv
// Shared definitions for the JK command sequencer: JK drive codes, FSM states
// and the JK next-state function.
package jk_cmd_seq_pkg;

  localparam int unsigned JK_W = 2;

  typedef logic [JK_W-1:0] jk_t;

  localparam jk_t JK_HOLD = 2'b00;
  localparam jk_t JK_RST  = 2'b01;
  localparam jk_t JK_SET  = 2'b10;
  localparam jk_t JK_TGL  = 2'b11;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Value a JK flip-flop holding q takes after one edge driven with code.
  function automatic logic jk_next(input logic q, input jk_t code);
    logic r;
    r = q;
    case (code)
      JK_RST:  r = 1'b0;
      JK_SET:  r = 1'b1;
      JK_TGL:  r = ~q;
      default: r = q;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/jk_cmd_seq_if.sv
// Command handshake bundle between an upstream command source and the sequencer.
interface jk_cmd_seq_if #(
  parameter int unsigned LEN_W = 8
) ();
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_code;
  logic [LEN_W-1:0] cmd_len;

  modport master (output cmd_valid, cmd_code, cmd_len, input cmd_ready);
  modport slave  (input cmd_valid, cmd_code, cmd_len, output cmd_ready);
endinterface

// File: rtl/jk_cmd_seq_jk_model.sv
// Shadow model of a single-cycle JK flip-flop: tracks the expected q and flags
// any disagreement with the real flip-flop's returned q.
module jk_model
  import jk_cmd_seq_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  jk_t  jk,
  input  logic q_fb,
  output logic exp_q,
  output logic exp_vld,
  output logic err
);

  // q_fb in this cycle reflects the edge that produced the current exp_q.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_q   <= 1'b0;
      exp_vld <= 1'b0;
      err     <= 1'b0;
    end else begin
      exp_q <= jk_next(exp_q, jk);
      if (jk == JK_RST || jk == JK_SET) begin
        exp_vld <= 1'b1;
      end
      if (exp_vld && (q_fb != exp_q)) begin
        err <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/jk_cmd_seq.sv
// Sequencer that drives a JK code downstream for a commanded number of cycles,
// with back-to-back command acceptance and a shadow-model consistency check.
module jk_cmd_seq
  import jk_cmd_seq_pkg::*;
#(
  parameter int unsigned LEN_W = 8
) (
  input  logic         clk,
  input  logic         rst,
  jk_cmd_seq_if.slave  cmd,
  output jk_t          jk,
  input  logic         q_fb,
  output logic         busy,
  output logic         done,
  output logic         exp_q,
  output logic         exp_vld,
  output logic         err
);

  state_t           state, state_nxt;
  logic [LEN_W-1:0] cnt, cnt_nxt;
  jk_t              code, code_nxt;
  logic             ready_nxt, busy_nxt, done_nxt;
  jk_t              jk_nxt;
  logic             hs;
  logic [LEN_W-1:0] len_eff;

  assign hs      = cmd.cmd_valid && cmd.cmd_ready;
  assign len_eff = (cmd.cmd_len == '0) ? LEN_W'(1) : cmd.cmd_len;

  // State and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ST_IDLE;
      cnt           <= '0;
      code          <= JK_HOLD;
      cmd.cmd_ready <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      jk            <= JK_HOLD;
    end else begin
      state         <= state_nxt;
      cnt           <= cnt_nxt;
      code          <= code_nxt;
      cmd.cmd_ready <= ready_nxt;
      busy          <= busy_nxt;
      done          <= done_nxt;
      jk            <= jk_nxt;
    end
  end

  // Next state, counter and latched code
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    code_nxt  = code;
    case (state)
      ST_IDLE: begin
        if (hs) begin
          state_nxt = ST_RUN;
          cnt_nxt   = len_eff;
          code_nxt  = jk_t'(cmd.cmd_code);
        end
      end
      ST_RUN: begin
        if (cnt == LEN_W'(1)) begin
          if (hs) begin
            cnt_nxt  = len_eff;
            code_nxt = jk_t'(cmd.cmd_code);
          end else begin
            state_nxt = ST_IDLE;
            cnt_nxt   = '0;
            code_nxt  = JK_HOLD;
          end
        end else begin
          cnt_nxt = cnt - LEN_W'(1);
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        cnt_nxt   = '0;
        code_nxt  = JK_HOLD;
      end
    endcase
  end

  // Output values for the upcoming cycle, registered above
  always_comb begin
    ready_nxt = 1'b1;
    busy_nxt  = 1'b0;
    done_nxt  = 1'b0;
    jk_nxt    = JK_HOLD;
    if (state_nxt == ST_RUN) begin
      busy_nxt  = 1'b1;
      jk_nxt    = code_nxt;
      done_nxt  = (cnt_nxt == LEN_W'(1));
      ready_nxt = (cnt_nxt == LEN_W'(1));
    end
  end

  jk_model u_model (
    .clk     (clk),
    .rst     (rst),
    .jk      (jk),
    .q_fb    (q_fb),
    .exp_q   (exp_q),
    .exp_vld (exp_vld),
    .err     (err)
  );

endmodule
